// File: rtl/memory_seq_sub.sv
// Memory subsystem with a sequencer: fetches instructions over a variable-latency handshake,
// holds PC/IR/data RAM/RDR, and presents decoded fields and strobes to the execute unit.
module memory_seq_sub #(
   parameter int unsigned ROM_WIDTH = 32,
   parameter int unsigned RAM_WIDTH = 8,
   parameter int unsigned PC_W      = 5,
   parameter int unsigned RAM_AW    = 5,
   parameter logic [6:0]  PORT_ADDR = 7'd67
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RUN,
   output logic [PC_W-1:0]      IMEM_ADDR,
   output logic                 IMEM_REQ,
   input  logic                 IMEM_VALID,
   input  logic [ROM_WIDTH-1:0] IMEM_DATA,
   input  logic [RAM_WIDTH-1:0] ALU_DATA,
   input  logic [RAM_WIDTH-1:0] PORT_READ_DATA,
   input  logic                 EXEC_DONE,
   output logic [3:0]           OPCODE,
   output logic                 I_FLAG,
   output logic [6:0]           ADDR_OUT,
   output logic [RAM_WIDTH-1:0] ROM_DATA,
   output logic                 INSTR_VALID,
   output logic [RAM_WIDTH-1:0] RAM_DATA,
   output logic                 RDR_VALID,
   output logic                 HALTED,
   output logic [PC_W-1:0]      PC_OUT
);

   localparam logic [3:0] OP_ST   = 4'd1;
   localparam logic [3:0] OP_LD   = 4'd2;
   localparam logic [3:0] OP_JMP  = 4'd3;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_WR,
      S_MEM_RD,
      S_EXEC,
      S_HALT
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [ROM_WIDTH-1:0] ir;
   logic [PC_W-1:0]      pc;
   logic [RAM_WIDTH-1:0] rdr;
   logic                 rdr_valid_q;
   logic [RAM_WIDTH-1:0] ram [2**RAM_AW];

   logic                 ir_load;
   logic                 pc_jump;
   logic                 ram_write;
   logic                 rdr_load;
   logic [3:0]           opcode;
   logic [6:0]           addr_field;
   logic [RAM_AW-1:0]    ram_idx;
   logic [RAM_WIDTH-1:0] store_data;
   logic                 unused_ir;

   assign opcode     = ir[ROM_WIDTH-1 -: 4];
   assign addr_field = ir[ROM_WIDTH-6 -: 7];
   assign ram_idx    = addr_field[RAM_AW-1:0];
   assign store_data = (addr_field == PORT_ADDR) ? PORT_READ_DATA : ALU_DATA;
   // The filler bits between the address field and the immediate carry no meaning here.
   assign unused_ir  = ^ir;

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      pc_jump   = 1'b0;
      ram_write = 1'b0;
      rdr_load  = 1'b0;
      case (state)
         S_IDLE: begin
            if (RUN) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (IMEM_VALID) begin
               ir_load   = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_ST:   state_nxt = S_MEM_WR;
               OP_LD:   state_nxt = S_MEM_RD;
               OP_JMP: begin
                  pc_jump   = 1'b1;
                  state_nxt = RUN ? S_FETCH : S_IDLE;
               end
               OP_HALT: state_nxt = S_HALT;
               default: state_nxt = S_EXEC;
            endcase
         end
         S_MEM_WR: begin
            ram_write = 1'b1;
            state_nxt = S_EXEC;
         end
         S_MEM_RD: begin
            rdr_load  = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (EXEC_DONE) state_nxt = RUN ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // PC advances when the IR captures a fetch; a jump overrides it from DECODE.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pc          <= '0;
         ir          <= '0;
         rdr         <= '0;
         rdr_valid_q <= 1'b0;
      end else begin
         rdr_valid_q <= rdr_load;
         if (ir_load) begin
            ir <= IMEM_DATA;
            pc <= pc + PC_W'(1);
         end else if (pc_jump) begin
            pc <= addr_field[PC_W-1:0];
         end
         if (rdr_load) rdr <= ram[ram_idx];
      end
   end

   // NOTE: the data RAM has no reset; its contents survive RST and it maps onto plain memory.
   always_ff @(posedge CLK) begin
      if (ram_write) ram[ram_idx] <= store_data;
   end

   assign IMEM_ADDR   = pc;
   assign IMEM_REQ    = (state == S_FETCH);
   assign OPCODE      = opcode;
   assign I_FLAG      = ir[ROM_WIDTH-5];
   assign ADDR_OUT    = addr_field;
   assign ROM_DATA    = ir[RAM_WIDTH-1:0];
   assign INSTR_VALID = (state == S_DECODE);
   assign RAM_DATA    = rdr;
   assign RDR_VALID   = rdr_valid_q;
   assign HALTED      = (state == S_HALT);
   assign PC_OUT      = pc;

endmodule

// File: tb/tb_memory_seq_sub.sv
// Randomised bench for memory_seq_sub: drives instruction transactions and checks them against
// a transaction-level model of PC, data RAM and RDR.
module tb_memory_seq_sub;

   localparam int PCN   = 32;
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [4:0]  imem_addr;
   logic        imem_req;
   logic        imem_valid;
   logic [31:0] imem_data;
   logic [7:0]  alu_data;
   logic [7:0]  port_read_data;
   logic        exec_done;
   logic [3:0]  opcode;
   logic        i_flag;
   logic [6:0]  addr_out;
   logic [7:0]  rom_data;
   logic        instr_valid;
   logic [7:0]  ram_data;
   logic        rdr_valid;
   logic        halted;
   logic [4:0]  pc_out;

   int          n_vec = 0;
   int          n_err = 0;
   int          m_pc;
   logic [7:0]  m_ram [DEPTH];
   bit          m_known [DEPTH];

   memory_seq_sub dut (
      .CLK(clk), .RST(rst_n), .RUN(run),
      .IMEM_ADDR(imem_addr), .IMEM_REQ(imem_req), .IMEM_VALID(imem_valid), .IMEM_DATA(imem_data),
      .ALU_DATA(alu_data), .PORT_READ_DATA(port_read_data), .EXEC_DONE(exec_done),
      .OPCODE(opcode), .I_FLAG(i_flag), .ADDR_OUT(addr_out), .ROM_DATA(rom_data),
      .INSTR_VALID(instr_valid), .RAM_DATA(ram_data), .RDR_VALID(rdr_valid),
      .HALTED(halted), .PC_OUT(pc_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_timeout", imem_req, 1);
   endtask

   // Block parked in IDLE: no fetch, PC holds the next instruction, then resume.
   task automatic idle_check();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_req", imem_req, 0);
         check("idle_pc", pc_out, m_pc);
      end
      run = 1'b1;
   endtask

   task automatic run_instr(input logic [3:0] op, input logic [6:0] addr, input int lat,
                            input int dly, input bit drop_run,
                            input logic [7:0] alu, input logic [7:0] port);
      logic [7:0]  imm  = 8'($urandom);
      logic        ifl  = 1'($urandom);
      logic [11:0] fill = 12'($urandom);
      logic [31:0] instr;
      int          a;
      instr = {op, ifl, addr, fill, imm};
      a     = int'(addr) % DEPTH;

      wait_req();
      check("imem_addr", imem_addr, m_pc);
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         check("req_held", imem_req, 1);
      end
      imem_valid = 1'b1;
      imem_data  = instr;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_data  = $urandom;
      m_pc       = (m_pc + 1) % PCN;
      check("instr_valid", instr_valid, 1);
      check("opcode", opcode, op);
      check("i_flag", i_flag, ifl);
      check("addr_out", addr_out, addr);
      check("rom_data", rom_data, imm);
      check("pc_after_fetch", pc_out, m_pc);
      check("req_drop", imem_req, 0);
      alu_data       = alu;
      port_read_data = port;
      exec_done      = 1'b0;

      if (op == 4'd15) return;
      if (op == 4'd3) begin
         m_pc = int'(addr) % PCN;
         if (drop_run) begin
            run = 1'b0;
            idle_check();
         end
         return;
      end
      if (op == 4'd1 || op == 4'd2) begin
         @(negedge clk);
         check("iv_pulse", instr_valid, 0);
         check("rdr_valid_early", rdr_valid, 0);
         if (op == 4'd1) begin
            m_ram[a]   = (addr == 7'd67) ? port : alu;
            m_known[a] = 1'b1;
         end
      end
      exec_done = (dly == 0);

      for (int k = 0; k <= dly; k++) begin
         @(negedge clk);
         alu_data       = $urandom;
         port_read_data = $urandom;
         imem_valid     = 1'($urandom);
         imem_data      = $urandom;
         check("exec_req", imem_req, 0);
         if (op == 4'd2) begin
            check("rdr_valid", rdr_valid, (k == 0) ? 1 : 0);
            if (m_known[a]) check("ram_data", ram_data, m_ram[a]);
         end
         if (k == 0 && drop_run) run = 1'b0;
         exec_done = (k == dly);
      end
      @(negedge clk);
      exec_done  = 1'b0;
      imem_valid = 1'b0;
      check("ir_hold", opcode, op);
      if (drop_run) idle_check();
   endtask

   initial begin
      rst_n          = 1'b0;
      run            = 1'b0;
      imem_valid     = 1'b0;
      imem_data      = '0;
      alu_data       = '0;
      port_read_data = '0;
      exec_done      = 1'b0;
      m_pc           = 0;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_pc", pc_out, 0);
      check("rst_ir", {opcode, i_flag, addr_out, rom_data}, 0);
      check("rst_misc", {instr_valid, rdr_valid, halted, ram_data}, 0);
      rst_n = 1'b1;
      run   = 1'b1;

      run_instr(4'd2, 7'd5, 3, 0, 1'b0, 8'h00, 8'h00);
      run_instr(4'd1, 7'd5, 1, 0, 1'b0, 8'h3C, 8'hC3);
      run_instr(4'd2, 7'd5, 2, 1, 1'b0, 8'h00, 8'h00);
      run_instr(4'd1, 7'd67, 1, 2, 1'b0, 8'h11, 8'h5A);
      run_instr(4'd2, 7'd3, 1, 0, 1'b0, 8'h00, 8'h00);
      run_instr(4'd3, 7'h1F, 2, 0, 1'b0, 8'h00, 8'h00);
      run_instr(4'd7, 7'd0, 1, 0, 1'b0, 8'h00, 8'h00);
      run_instr(4'd5, 7'd9, 1, 4, 1'b1, 8'h00, 8'h00);

      for (int i = 0; i < DEPTH; i++)
         run_instr(4'd1, 7'(i), $urandom_range(1, 3), $urandom_range(0, 2), 1'b0,
                   8'($urandom), 8'($urandom));

      for (int i = 0; i < 100; i++) begin
         int          r  = $urandom_range(0, 9);
         logic [3:0]  op;
         if (r < 3)       op = 4'd1;
         else if (r < 6)  op = 4'd2;
         else if (r == 6) op = 4'd3;
         else if (r == 7) op = 4'd0;
         else             op = 4'($urandom_range(4, 14));
         run_instr(op, 7'($urandom_range(0, 127)), $urandom_range(1, 5), $urandom_range(0, 4),
                   ($urandom_range(0, 5) == 0), 8'($urandom), 8'($urandom));
      end

      run_instr(4'd15, 7'd0, 1, 0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halted", halted, 1);
         check("halt_req", imem_req, 0);
         run        = 1'b1;
         exec_done  = 1'($urandom);
         imem_valid = 1'($urandom);
      end
      #2 rst_n = 1'b0;
      #1;
      check("halt_rst_flags", {halted, imem_req, instr_valid, rdr_valid}, 0);
      check("halt_rst_regs", {opcode, i_flag, addr_out, rom_data, ram_data, pc_out, imem_addr}, 0);
      @(negedge clk);
      exec_done  = 1'b0;
      imem_valid = 1'b0;
      rst_n      = 1'b1;
      m_pc       = 0;

      wait_req();
      imem_valid = 1'b1;
      imem_data  = 32'h2050_00AA;
      #1 rst_n = 1'b0;
      #1;
      check("fetch_abort_req", imem_req, 0);
      @(negedge clk);
      imem_valid = 1'b0;
      rst_n      = 1'b1;
      check("fetch_abort_ir", opcode, 0);
      run_instr(4'd2, 7'd5, 2, 1, 1'b0, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/memory_seq_sub.md
Name: memory_seq_sub

Overview:
- Parametrised successor of the fetch/IR/RAM/RDR memory subsystem.
- Adds a sequencer FSM, a variable-latency external instruction-memory handshake, jump and halt handling, a port-mapped store source and a run/stop control.
- Sits between the external program store and the execute/ALU unit.
- Holds the PC, instruction register (IR), data RAM and RAM data register (RDR), and presents decoded fields to the control path.

Parameters:
- ROM_WIDTH, 32, instruction width; must be ≥ 12 + RAM_WIDTH.
- RAM_WIDTH, 8, data RAM / RDR word width.
- PC_W, 5, program counter width; instruction space is 2^PC_W words.
- RAM_AW, 5, data RAM address width; depth is 2^RAM_AW; must be ≤ 7.
- PORT_ADDR, 67, 7-bit address field value that selects PORT_READ_DATA as the store source.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- RUN  in  1  enables fetching; sampled in IDLE and at instruction boundaries.
- IMEM_ADDR  out  PC_W  fetch address (current PC).
- IMEM_REQ  out  1  fetch request; held high until IMEM_VALID.
- IMEM_VALID  in  1  IMEM_DATA valid this cycle.
- IMEM_DATA  in  ROM_WIDTH  fetched instruction.
- ALU_DATA  in  RAM_WIDTH  default store data.
- PORT_READ_DATA  in  RAM_WIDTH  store data when address field == PORT_ADDR.
- EXEC_DONE  in  1  execute unit finished the current instruction.
- OPCODE  out  4  IR[ROM_WIDTH-1 -: 4].
- I_FLAG  out  1  IR[ROM_WIDTH-5].
- ADDR_OUT  out  7  IR[ROM_WIDTH-6 -: 7].
- ROM_DATA  out  RAM_WIDTH  IR[RAM_WIDTH-1:0] (immediate).
- INSTR_VALID  out  1  one-cycle pulse in DECODE.
- RAM_DATA  out  RAM_WIDTH  RDR contents.
- RDR_VALID  out  1  one-cycle pulse, the cycle after RDR loads.
- HALTED  out  1  high in HALT state.
- PC_OUT  out  PC_W  current PC.

Behaviour:
- Reset (RST=0, async): state=IDLE, PC=0, IR=0, RDR=0, RAM_WRITE=0, all outputs 0. RAM contents are not cleared.
- Opcodes: 1=ST, 2=LD, 3=JMP, 15=HALT, others=EXEC-only.
- RAM index a = ADDR_OUT[RAM_AW-1:0]; upper address bits are ignored for the index.
- IDLE: if RUN → FETCH.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC.
  - On a cycle with IMEM_VALID: IR<=IMEM_DATA, PC<=PC+1 mod 2^PC_W, → DECODE.
  - Minimum latency 1 cycle; no upper bound.
  - IMEM_VALID outside FETCH is ignored.
- DECODE: INSTR_VALID=1 for exactly this cycle. Next state by opcode:
  - ST → MEM_WR.
  - LD → MEM_RD.
  - JMP → PC<=ADDR_OUT[PC_W-1:0], then FETCH if RUN, else IDLE.
  - HALT → HALT.
  - others → EXEC.
- MEM_WR: RAM[a]<=(ADDR_OUT==PORT_ADDR) ? PORT_READ_DATA : ALU_DATA, sampled this cycle. → EXEC.
- MEM_RD: RDR<=RAM[a] at end of cycle. → EXEC; RDR_VALID=1 during the first EXEC cycle.
  - An LD immediately after an ST to the same address returns the new data.
- EXEC: waits for EXEC_DONE, which may already be high on entry.
  - On EXEC_DONE: → FETCH if RUN, else → IDLE.
- HALT: HALTED=1. Only reset leaves this state; RUN and EXEC_DONE are ignored.
- RUN dropping mid-instruction does not abort it; the block stops at the next boundary with PC pointing to the next instruction.
- Decoded outputs hold IR continuously and change only when the IR loads.
- RDR holds its value until the next LD.
- Reset mid-fetch or mid-exec aborts immediately; a pending IMEM response is discarded.

Test Plan:
- Reset, RUN=1, IMEM_VALID 3 cycles after IMEM_REQ, IMEM_DATA=0x2050_00AA (LD, addr 5) → IMEM_REQ held 3 cycles; INSTR_VALID pulse with OPCODE=2, ADDR_OUT=5, ROM_DATA=0xAA; PC_OUT=1.
- ST addr 5 with ALU_DATA=0x3C, EXEC_DONE=1, then LD addr 5 → RDR_VALID pulse, RAM_DATA=0x3C.
- ST with ADDR_OUT=67 (RAM_AW=5, index 3), PORT_READ_DATA=0x5A, ALU_DATA=0x11; then LD addr 3 → RAM_DATA=0x5A.
- JMP to 0x1F, then next fetch → IMEM_ADDR=31; after that fetch completes, PC_OUT wraps to 0.
- HALT opcode 0xF → HALTED=1, IMEM_REQ stays 0 for 20 cycles despite RUN=1; RST low → all outputs 0.
- RUN drops while in EXEC; EXEC_DONE after 4 cycles → IDLE, IMEM_REQ=0; RUN high → fetch resumes at the saved PC.
